// File: rtl/fifo_serial_tx.sv
// Serial transmitter that drains an upstream synchronous FIFO, one word per frame:
// a start bit, data_width+1 data bits LSB first, then a stop bit.
module fifo_serial_tx #(
  parameter int data_width   = 7,
  parameter int clks_per_bit = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                empty,
  input  logic [data_width:0] DATAIN,
  input  logic                enable,
  output logic                rn,
  output logic                txd,
  output logic                busy,
  output logic                done
);

  localparam int BAUD_W = $clog2(clks_per_bit);
  // Bit counter must reach data_width+1 at the end of a frame without wrapping.
  localparam int BIT_W  = $clog2(data_width + 2);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_width);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [data_width:0]   shift, shift_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic [BAUD_W-1:0]     baud_cnt, baud_n;
  logic                  txd_n, busy_n, done_n;
  logic                  baud_end;
  logic                  can_fetch;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign can_fetch = enable && !empty;
  assign rn        = (state == FETCH);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    baud_n  = baud_cnt;

    if (state == START || state == DATA || state == STOP)
      baud_n = baud_end ? '0 : baud_cnt + BAUD_ONE;

    case (state)
      IDLE:  if (can_fetch) state_n = FETCH;
      FETCH: state_n = LOAD;
      LOAD: begin
        shift_n = DATAIN;
        bit_n   = '0;
        baud_n  = '0;
        state_n = START;
      end
      START: if (baud_end) state_n = DATA;
      DATA: begin
        if (baud_end) begin
          shift_n = shift >> 1;
          bit_n   = bit_cnt + BIT_ONE;
          if (bit_cnt == BIT_LAST) state_n = STOP;
        end
      end
      STOP:    if (baud_end) state_n = can_fetch ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are derived from the next state so the registered copies line up with it.
    txd_n = 1'b1;
    if (state_n == START)     txd_n = 1'b0;
    else if (state_n == DATA) txd_n = shift_n[0];
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (baud_n == BAUD_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_n;
      baud_cnt <= baud_n;
      txd      <= txd_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule
